// File: rtl/mxu_result_packer.sv
// mxu_result_packer: serialises MXU result vectors element by element, packs them MSB-first into 64-bit words,
// and streams the words out through a small FIFO with tlast.
module mxu_result_packer #(
  parameter int M              = 3,
  parameter int max_data_width = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [M*max_data_width-1:0] y,
  input  logic                      y_valid,
  input  logic                      y_last,
  output logic                      y_ready,
  output logic [63:0]               m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      busy
);
  localparam int W  = max_data_width;
  localparam int L  = 64 / W;
  localparam int EW = $clog2(M + 1);
  localparam int PW = $clog2(L + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;
  state_t state, state_d;
  logic [M*W-1:0] hold_q;
  logic last_q, advance, push, push_last, done, last_elem, full, empty, pop;
  logic [EW-1:0] elem_cnt;
  logic [PW-1:0] pack_cnt, pack_cnt_d;
  logic [63:0] pack_q, pack_d, word, din;
  logic [W-1:0] elem;
  logic [64:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  assign elem      = W'(hold_q >> ((M - 1 - elem_cnt) * W));
  assign word      = pack_q | ((64'(elem) << (64 - W)) >> (pack_cnt * W));
  assign done      = pack_cnt == PW'(L - 1);
  assign last_elem = elem_cnt == EW'(M - 1);
  assign din       = state == FLUSH ? pack_q : word;
  assign y_ready   = reset && state == IDLE;
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty     = wptr == rptr;
  assign m_tvalid  = !empty;
  assign pop       = m_tvalid && m_tready;
  assign {m_tlast, m_tdata} = empty ? 65'd0 : mem[rptr[AW-1:0]];
  assign busy      = state != IDLE || !empty;
  always_comb begin
    state_d    = state;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt;
    advance    = 1'b0;
    push       = 1'b0;
    push_last  = 1'b0;
    case (state)
      IDLE: state_d = y_valid && y_ready ? SHIFT : IDLE;
      SHIFT: if (!(done && full)) begin
        advance    = 1'b1;
        push       = done;
        push_last  = last_q && last_elem;
        pack_d     = done ? 64'd0 : word;
        pack_cnt_d = done ? '0 : pack_cnt + 1'b1;
        if (last_elem) state_d = last_q && !done ? FLUSH : IDLE;
      end
      FLUSH: if (!full) begin
        push       = 1'b1;
        push_last  = 1'b1;
        pack_d     = 64'd0;
        pack_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_q   <= '0;
      last_q   <= 1'b0;
      elem_cnt <= '0;
      pack_cnt <= '0;
      pack_q   <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      state    <= state_d;
      pack_q   <= pack_d;
      pack_cnt <= pack_cnt_d;
      if (state == IDLE && y_valid) begin
        hold_q   <= y;
        last_q   <= y_last;
        elem_cnt <= '0;
      end else if (advance) elem_cnt <= elem_cnt + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end
  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {push_last, din};
  end
endmodule
